// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer execute unit for the EX stage.
// Accepts a decoded ALU op over a valid/ready handshake and returns a
// registered result with eq/lt compare flags. Shifts iterate one bit per
// cycle through an internal accumulator; all other ops finish in one cycle.
// Build option: define ALU_MC_FAST_SHIFT_EN to replace the iterative shifter
// with a single-cycle barrel shifter (the SHIFT state and counter then vanish).
module alu_mc #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_opsel,
    input  logic            i_sub,
    input  logic            i_unsigned,
    input  logic            i_arith,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_eq,
    output logic            o_lt
);

    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   shamt;
    logic            is_shift;
    logic            lt;
    logic            eq;
    logic [XLEN-1:0] alu_res;

    assign shamt    = i_op2[SW-1:0];
    assign is_shift = (i_opsel[1:0] == 2'b01);
    assign o_ready  = (state == S_IDLE);
    assign o_valid  = (state == S_DONE);

    // Single-cycle datapath and compare flags from the live request inputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (that would infer a latch).
        alu_res = '0;
        eq      = (i_op1 == i_op2);
        lt      = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));
        case (i_opsel)
            3'b000:         alu_res = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
            3'b010, 3'b011: alu_res = {{(XLEN-1){1'b0}}, lt};
            3'b100:         alu_res = i_op1 ^ i_op2;
            3'b110:         alu_res = i_op1 | i_op2;
            3'b111:         alu_res = i_op1 & i_op2;
`ifdef ALU_MC_FAST_SHIFT_EN
            3'b001:         alu_res = i_op1 << shamt;
            3'b101:         alu_res = i_arith ? XLEN'($signed(i_op1) >>> shamt) : (i_op1 >> shamt);
`else
            // Only the shamt==0 shift takes this path; the value is op1 unchanged.
            3'b001, 3'b101: alu_res = i_op1;
`endif
            default:        alu_res = '0;
        endcase
    end

`ifndef ALU_MC_FAST_SHIFT_EN
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [SW-1:0]   cnt;
    logic            shift_left;
    logic            shift_arith;

    // One-bit shift step of the accumulator using the captured direction/fill.
    always_comb begin
        acc_next = shift_left ? {acc[XLEN-2:0], 1'b0}
                              : {shift_arith & acc[XLEN-1], acc[XLEN-1:1]};
    end
`endif

    // Control FSM plus result/flag registers; flush overrides every handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the accumulator is reset too; it is small and keeps sim free of X after a mid-shift reset.
            state    <= S_IDLE;
            o_result <= '0;
            o_eq     <= 1'b0;
            o_lt     <= 1'b0;
`ifndef ALU_MC_FAST_SHIFT_EN
            acc         <= '0;
            cnt         <= '0;
            shift_left  <= 1'b0;
            shift_arith <= 1'b0;
`endif
        end else if (i_flush) begin
            state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        o_eq <= eq;
                        o_lt <= lt;
`ifndef ALU_MC_FAST_SHIFT_EN
                        if (is_shift && (shamt != '0)) begin
                            acc         <= i_op1;
                            cnt         <= shamt;
                            shift_left  <= ~i_opsel[2];
                            shift_arith <= i_arith;
                            state       <= S_SHIFT;
                        end else begin
                            o_result <= alu_res;
                            state    <= S_DONE;
                        end
`else
                        o_result <= alu_res;
                        state    <= S_DONE;
`endif
                    end
                end
`ifndef ALU_MC_FAST_SHIFT_EN
                S_SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - {{(SW-1){1'b0}}, 1'b1};
                    if (cnt == {{(SW-1){1'b0}}, 1'b1}) begin
                        o_result <= acc_next;
                        state    <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (i_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_MC_FAST_SHIFT_EN
    // is_shift only steers the iterative shifter; keep it referenced.
    logic unused_fast;
    assign unused_fast = is_shift;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (default build, iterative shifter, XLEN=32).
module tb_alu_mc;

    localparam int XLEN = 32;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_opsel;
    logic            i_sub;
    logic            i_unsigned;
    logic            i_arith;
    logic [XLEN-1:0] i_op1;
    logic [XLEN-1:0] i_op2;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_eq;
    logic            o_lt;

    int checks = 0;
    int errors = 0;

    alu_mc #(.XLEN(XLEN)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_opsel    (i_opsel),
        .i_sub      (i_sub),
        .i_unsigned (i_unsigned),
        .i_arith    (i_arith),
        .i_op1      (i_op1),
        .i_op2      (i_op2),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_eq       (o_eq),
        .o_lt       (o_lt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one op, scramble inputs after accept, measure latency, check
    // result/flags, hold i_ready low for 'hold' cycles, then retire.
    task automatic run_op(input string tag, input logic [2:0] opsel, input logic sub,
                          input logic uns, input logic arith,
                          input logic [XLEN-1:0] op1, input logic [XLEN-1:0] op2,
                          input logic [XLEN-1:0] exp_res, input logic exp_eq,
                          input logic exp_lt, input int exp_lat, input int hold);
        int lat;
        i_opsel = opsel; i_sub = sub; i_unsigned = uns; i_arith = arith;
        i_op1 = op1; i_op2 = op2; i_valid = 1'b1; i_ready = 1'b0;
        tick();
        i_valid = 1'b0;
        i_opsel = ~opsel; i_sub = ~sub; i_unsigned = ~uns; i_arith = ~arith;
        i_op1 = ~op1; i_op2 = ~op2;
        lat = 1;
        while (!o_valid && lat < 64) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(o_result), 64'(exp_res));
        check({tag, " eq"}, 64'(o_eq), 64'(exp_eq));
        check({tag, " lt"}, 64'(o_lt), 64'(exp_lt));
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, " hold valid"}, 64'(o_valid), 64'd1);
            check({tag, " hold ready"}, 64'(o_ready), 64'd0);
            check({tag, " hold result"}, 64'(o_result), 64'(exp_res));
            check({tag, " hold flags"}, 64'({o_eq, o_lt}), 64'({exp_eq, exp_lt}));
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check({tag, " retire ready"}, 64'(o_ready), 64'd1);
        check({tag, " retire valid"}, 64'(o_valid), 64'd0);
    endtask

    initial begin
        int seen;
        i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_opsel = '0; i_sub = 1'b0; i_unsigned = 1'b0; i_arith = 1'b0;
        i_op1 = '0; i_op2 = '0;
        #22;
        i_rst_n = 1'b1;
        tick();
        check("reset ready", 64'(o_ready), 64'd1);
        check("reset valid", 64'(o_valid), 64'd0);
        check("reset result", 64'(o_result), 64'd0);
        check("reset flags", 64'({o_eq, o_lt}), 64'd0);

        // opsel sub uns arith op1 op2 result eq lt latency hold
        run_op("add",   3'b000, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1, 0);
        run_op("sub",   3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1, 0);
        run_op("sra4",  3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b1, 5, 0);
        run_op("srl4",  3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'd4, 32'h0800_0001, 1'b0, 1'b1, 5, 0);
        run_op("sra0",  3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'd32, 32'h8000_0010, 1'b0, 1'b1, 1, 0);
        run_op("sltu",  3'b011, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1, 0);
        run_op("slt",   3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b1, 1, 0);
        run_op("slt011",3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b1, 1, 0);
        run_op("slteq", 3'b010, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b0, 1, 0);
        run_op("xoreq", 3'b100, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b0, 1, 0);
        run_op("sll31", 3'b001, 1'b0, 1'b0, 1'b0, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b1, 32, 0);
        run_op("or",    3'b110, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'hFFF0, 1'b0, 1'b0, 1, 0);
        run_op("and",   3'b111, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0, 1, 0);
        run_op("bp",    3'b000, 1'b0, 1'b0, 1'b0, 32'h5, 32'h7, 32'hC, 1'b0, 1'b1, 1, 5);

        // Flush mid-shift: accept on cycle N, flush during N+3.
        i_opsel = 3'b001; i_op1 = 32'h1; i_op2 = 32'd31; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_flush = 1'b1;
        check("flush no valid", 64'(o_valid), 64'd0);
        tick();
        i_flush = 1'b0;
        check("flush ready", 64'(o_ready), 64'd1);
        check("flush valid", 64'(o_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (o_valid) seen++;
        end
        check("flush stays idle", 64'(seen), 64'd0);
        run_op("xor", 3'b100, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1'b0, 1, 0);

        // Flush wins over a simultaneous accept.
        i_opsel = 3'b000; i_op1 = 32'h1; i_op2 = 32'h1; i_valid = 1'b1; i_flush = 1'b1;
        tick();
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush vs accept valid", 64'(o_valid), 64'd0);
        check("flush vs accept ready", 64'(o_ready), 64'd1);

        // Asynchronous reset between edges, mid-shift.
        i_opsel = 3'b001; i_op1 = 32'h1; i_op2 = 32'd10; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        check("pre-reset busy", 64'(o_ready), 64'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async reset valid", 64'(o_valid), 64'd0);
        check("async reset result", 64'(o_result), 64'd0);
        #3;
        i_rst_n = 1'b1;
        tick();
        check("post-reset ready", 64'(o_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (o_valid) seen++;
        end
        check("post-reset no result", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
